bin_to_bcd_seq: RTL



---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Contents: FSM state enum, default digit count, BCD digit type and a
// helper that returns the largest value representable in N BCD digits.
package bcd_pkg;

   localparam int unsigned DIGITS_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   // 10^digits - 1
   function automatic int unsigned max_bcd_val(input int unsigned digits);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < digits; i++) begin
         p = p * 10;
      end
      return p - 1;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 correction for one BCD nibble (shift-and-add-3 step).
// Ports:
//   din    - BCD digit before correction
//   dout_c - din + 3 when din >= 5, else din (stays within 4 bits)
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  bcd_digit_t din,
   output bcd_digit_t dout_c
);

   assign dout_c = (din >= 4'd5) ? bcd_digit_t'(din + 4'd3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter, one bit per clock.
// Optional leading-zero blanking mask is enabled by the macro
// BCD_LEADING_BLANK_EN; without it blank_mask is tied to zero.
// Ports:
//   clk        - system clock
//   rst        - synchronous reset, active low
//   bin_in     - unsigned binary value to convert
//   in_valid   - bin_in valid this cycle
//   in_ready   - converter idle and able to accept
//   bcd_out    - packed BCD result, most-significant digit in top nibble
//   out_valid  - one-cycle pulse when bcd_out has just been updated
//   overflow   - last accepted input was clamped to 10^DIGITS-1
//   blank_mask - bit i set when digit i is a leading zero
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = DIGITS_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIN_W-1:0]      bin_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  out_valid,
   output logic                  overflow,
   output logic [DIGITS-1:0]     blank_mask
);

   localparam int unsigned ACC_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(max_bcd_val(DIGITS));

   state_t              state_q, state_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_pend_q, ovf_pend_d;
   logic [ACC_W-1:0]    bcd_out_q, bcd_out_d;
   logic                out_valid_q, out_valid_d;
   logic                overflow_q, overflow_d;
   logic [DIGITS-1:0]   blank_q, blank_d;
   logic [ACC_W-1:0]    acc_adj;
   logic [DIGITS-1:0]   blank_c;

   // Per-digit add-3 correction applied before every shift
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din    (acc_q[4*g +: 4]),
         .dout_c (acc_adj[4*g +: 4])
      );
   end

`ifdef BCD_LEADING_BLANK_EN
   // A digit is blank when it and every more-significant digit are zero
   logic zero_above;
   always_comb begin
      blank_c    = '0;
      zero_above = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         zero_above = zero_above & (acc_q[4*i +: 4] == 4'd0);
         blank_c[i] = zero_above;
      end
   end
`else
   assign blank_c = '0;
`endif

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_pend_q  <= 1'b0;
         bcd_out_q   <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         blank_q     <= '0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_pend_q  <= ovf_pend_d;
         bcd_out_q   <= bcd_out_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
         blank_q     <= blank_d;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_pend_d  = ovf_pend_q;
      bcd_out_d   = bcd_out_q;
      overflow_d  = overflow_q;
      blank_d     = blank_q;
      out_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Clamp keeps the accumulator free of carry out of the top digit
               if (bin_in > MAX_VAL) begin
                  bin_d      = MAX_VAL;
                  ovf_pend_d = 1'b1;
               end else begin
                  bin_d      = bin_in;
                  ovf_pend_d = 1'b0;
               end
               acc_d   = '0;
               cnt_d   = CNT_W'(BIN_W);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_out_d   = acc_q;
            overflow_d  = ovf_pend_q;
            blank_d     = blank_c;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready   = (state_q == IDLE);
   assign bcd_out    = bcd_out_q;
   assign out_valid  = out_valid_q;
   assign overflow   = overflow_q;
   assign blank_mask = blank_q;

endmodule
